free_play_ctrl: RTL
===================

# free_play_ctrl

Parametrised free-play front-end for the electronic organ. It samples N_KEYS note keys and three octave buttons (up/center/down), then debounces and edge-detects the buttons. It keeps a saturating octave register and drives the polyphonic note vector and octave shift into the sound generator. It also provides a monophonic last-note-priority channel for the display and scoring logic, with an optional sustain latch.

## Interface
- N_KEYS, 8, number of note keys (2..32)
- OCT_W, 2, width of octave shift output
- N_OCT, 3, number of legal octave values (1..2^OCT_W); legal shift range 0..N_OCT-1
- OCT_DEFAULT, 0, octave after reset and on center press (< N_OCT)
- DEB_CYCLES, 20000, consecutive stable cycles required to accept a button change (>= 2)
- IDX_W, $clog2(N_KEYS), width of note_idx
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- keys  in  N_KEYS  raw key levels, asynchronous, 1 = pressed
- but_up  in  1  raw octave-up button
- but_center  in  1  raw octave-reset button
- but_down  in  1  raw octave-down button
- sustain  in  1  raw sustain level (used only with FREE_SUSTAIN_EN)
- notes  out  N_KEYS  note vector to sound generator; keys[i] drives notes[N_KEYS-1-i]
- shift  out  OCT_W  current octave
- note_valid  out  1  at least one note sounding
- note_idx  out  IDX_W  monophonic note, key index (not reversed)
- note_on  out  1  one-cycle pulse when note_idx takes a new value from a fresh key press

## Operation
- Every raw input passes through a 2-flop synchronizer. There is no debounce on keys.
- Each button has a counter. The sync'd level is compared with the debounced level. On mismatch the counter increments. On match it clears. When the counter reaches DEB_CYCLES-1 with a mismatch still present, the debounced level flips and the counter clears.
- A rising edge of a debounced button is an event. Only one event acts per cycle, priority center > up > down.
  - center: shift <= OCT_DEFAULT.
  - up: shift <= shift+1, saturating at N_OCT-1.
  - down: shift <= shift-1, saturating at 0.
- Holding a button produces exactly one event. There is no auto-repeat.
- live = sync'd keys. Press edges = live & ~live_prev.
- Monophonic channel states: IDLE (note_valid=0) and HOLD (note_valid=1).
  - IDLE -> HOLD on any press edge. note_idx is set to the lowest-index pressed key and note_on pulses.
  - In HOLD, a new press edge sets note_idx to the lowest-index new key and pulses note_on, even if that value equals the current note_idx.
  - In HOLD, if key note_idx releases and other keys are held, note_idx falls back to the lowest-index held key with no note_on pulse.
  - In HOLD, if no keys are held (or sustained), go to IDLE. note_idx keeps its last value.
  - A press edge and the release of the current note in the same cycle: the press edge wins.
- Arithmetic on shift is done at OCT_W+1 bits before saturation. There is no wrap-around.

## Timing
- Reset values: notes=0, shift=OCT_DEFAULT, note_valid=0, note_idx=0, note_on=0. All synchronizers, counters, debounced levels (0) and the latch are cleared.
- Reset asserted mid-debounce or mid-note: all state is discarded on the next edge. Buttons held across reset need a full DEB_CYCLES before an event fires.
- Key change at input before edge t: notes updates after edge t+2, visible at cycle t+3. note_on, note_idx and note_valid follow the same latency.
- Button steady from edge t: the debounced level flips at edge t+DEB_CYCLES+1 and shift updates one edge later.
- A glitch shorter than DEB_CYCLES sync'd cycles is fully rejected.

## Configuration
- FREE_SUSTAIN_EN defined:
  - The sync'd sustain is level-sensitive with no debounce.
  - While sustain=1, a latch register ORs in press edges. The sound vector and the monophonic "held" set both use live | latch.
  - On the sync'd falling edge of sustain the latch clears, so notes reverts to live on that edge.
- FREE_SUSTAIN_EN undefined: the sustain port is ignored, no latch register exists, and notes reflects live keys only.

## Test plan
- Reset, then keys=8'b0000_0001 -> notes=8'b1000_0000, note_valid=1, note_idx=0, one note_on pulse 3 cycles after input change.
- DEB_CYCLES=4, shift=0, hold but_up 20 cycles -> shift=1 exactly once; press up twice more with N_OCT=3 -> shift stays 2; center -> shift=0.
- DEB_CYCLES=4, but_down pulses of 3 cycles -> shift unchanged. Up and center rising in the same cycle -> shift=OCT_DEFAULT.
- Hold key 5, then press key 2 -> note_idx=2 with note_on. Release 2 -> note_idx=5 with no pulse. Release 5 -> note_valid=0, note_idx stays 5.
- FREE_SUSTAIN_EN: sustain=1, tap key 3 then release -> notes bit 4 stays 1 and note_valid=1. Drop sustain -> notes=0 and note_valid=0 within 3 cycles.
- Assert rst for 1 cycle while shift=2 and key 1 held -> shift=0 and notes=0 after the edge. Key still held -> notes bit 6 returns 3 cycles after rst drops, with note_on.

Source files
------------

// File: rtl/free_play_if.sv
// -----------------------------------------------------------------------------
// free_play_if
// Bundle between the organ key/button panel and the free-play front-end.
//   keys        panel -> ctrl  raw key levels, 1 = pressed
//   but_up      panel -> ctrl  raw octave-up button
//   but_center  panel -> ctrl  raw octave-reset button
//   but_down    panel -> ctrl  raw octave-down button
//   sustain     panel -> ctrl  raw sustain level
//   notes       ctrl -> sound  polyphonic note vector (key order reversed)
//   shift       ctrl -> sound  current octave
//   note_valid  ctrl -> disp   monophonic channel has a note
//   note_idx    ctrl -> disp   monophonic note key index
//   note_on     ctrl -> disp   one-cycle pulse on a fresh monophonic note
// master = panel/consumer side, slave = the controller.
// -----------------------------------------------------------------------------
interface free_play_if #(
   parameter int N_KEYS = 8,
   parameter int OCT_W  = 2,
   parameter int IDX_W  = $clog2(N_KEYS)
);
   logic [N_KEYS-1:0] keys;
   logic              but_up;
   logic              but_center;
   logic              but_down;
   logic              sustain;
   logic [N_KEYS-1:0] notes;
   logic [OCT_W-1:0]  shift;
   logic              note_valid;
   logic [IDX_W-1:0]  note_idx;
   logic              note_on;

   modport master (
      output keys, but_up, but_center, but_down, sustain,
      input  notes, shift, note_valid, note_idx, note_on
   );

   modport slave (
      input  keys, but_up, but_center, but_down, sustain,
      output notes, shift, note_valid, note_idx, note_on
   );
endinterface

// File: rtl/free_play_ctrl.sv
// -----------------------------------------------------------------------------
// free_play_ctrl
// Free-play front-end of the electronic organ. Synchronises the raw keys and
// the three octave buttons, debounces and edge-detects the buttons, keeps a
// saturating octave register and drives the polyphonic note vector plus a
// monophonic last-note-priority channel.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active high
//   bus   free_play_if.slave (keys/buttons/sustain in, notes/shift/mono out)
//
// Build option:
//   FREE_SUSTAIN_EN  when defined, the sustain input latches pressed keys
//                    into the held set until sustain is released. When not
//                    defined the sustain input is ignored.
// -----------------------------------------------------------------------------
module free_play_ctrl #(
   parameter int N_KEYS      = 8,
   parameter int OCT_W       = 2,
   parameter int N_OCT       = 3,
   parameter int OCT_DEFAULT = 0,
   parameter int DEB_CYCLES  = 20000,
   parameter int IDX_W       = $clog2(N_KEYS)
) (
   input  logic        clk,
   input  logic        rst,
   free_play_if.slave  bus
);

   localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [OCT_W:0]   OCT_MAX  = (OCT_W+1)'(N_OCT - 1);
   localparam logic [OCT_W-1:0] OCT_RST  = OCT_W'(OCT_DEFAULT);

   // Button slots in the packed button vectors.
   localparam int B_UP     = 0;
   localparam int B_CENTER = 1;
   localparam int B_DOWN   = 2;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } mono_state_t;

   // ---------------------------------------------------------------------------
   // Input synchronisers
   // ---------------------------------------------------------------------------
   logic [N_KEYS-1:0] keys_s1;
   logic [N_KEYS-1:0] live;
   logic [N_KEYS-1:0] live_prev;
   logic [2:0]        btn_s1;
   logic [2:0]        btn_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         keys_s1   <= '0;
         live      <= '0;
         live_prev <= '0;
         btn_s1    <= '0;
         btn_s2    <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the value from
         // before the edge, which is what makes this a two-stage chain.
         keys_s1   <= bus.keys;
         live      <= keys_s1;
         live_prev <= live;
         btn_s1    <= {bus.but_down, bus.but_center, bus.but_up};
         btn_s2    <= btn_s1;
      end
   end

   // ---------------------------------------------------------------------------
   // Button debounce: a change is accepted only after DEB_CYCLES consecutive
   // synchronised samples disagree with the debounced level.
   // ---------------------------------------------------------------------------
   logic [2:0]       btn_deb;
   logic [2:0]       btn_deb_prev;
   logic [CNT_W-1:0] btn_cnt [3];
   logic [2:0]       btn_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_deb      <= '0;
         btn_deb_prev <= '0;
         for (int b = 0; b < 3; b++) begin
            btn_cnt[b] <= '0;
         end
      end else begin
         btn_deb_prev <= btn_deb;
         for (int b = 0; b < 3; b++) begin
            if (btn_s2[b] == btn_deb[b]) begin
               btn_cnt[b] <= '0;
            end else if (btn_cnt[b] == CNT_LAST) begin
               btn_deb[b] <= btn_s2[b];
               btn_cnt[b] <= '0;
            end else begin
               btn_cnt[b] <= btn_cnt[b] + CNT_W'(1);
            end
         end
      end
   end

   // A held button rises exactly once, so there is no auto-repeat.
   assign btn_rise = btn_deb & ~btn_deb_prev;

   // ---------------------------------------------------------------------------
   // Octave register. Arithmetic is one bit wider than shift so that both the
   // overflow above N_OCT-1 and the borrow below zero are visible before
   // saturation; nothing ever wraps.
   // ---------------------------------------------------------------------------
   logic [OCT_W-1:0] shift_q;
   logic [OCT_W:0]   shift_wide;
   logic [OCT_W:0]   shift_inc;
   logic [OCT_W:0]   shift_dec;
   logic [OCT_W:0]   shift_up_sat;
   logic [OCT_W:0]   shift_dn_sat;

   always_comb begin
      shift_wide   = {1'b0, shift_q};
      shift_inc    = shift_wide + (OCT_W+1)'(1);
      shift_dec    = shift_wide - (OCT_W+1)'(1);
      shift_up_sat = (shift_inc > OCT_MAX) ? OCT_MAX : shift_inc;
      // Top bit set after the subtraction means the result went below zero.
      shift_dn_sat = shift_dec[OCT_W] ? '0 : shift_dec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= OCT_RST;
      end else if (btn_rise[B_CENTER]) begin
         shift_q <= OCT_RST;
      end else if (btn_rise[B_UP]) begin
         shift_q <= shift_up_sat[OCT_W-1:0];
      end else if (btn_rise[B_DOWN]) begin
         shift_q <= shift_dn_sat[OCT_W-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Held-key set (live keys, optionally extended by the sustain latch)
   // ---------------------------------------------------------------------------
   logic [N_KEYS-1:0] press;
   logic [N_KEYS-1:0] held;

   assign press = live & ~live_prev;

`ifdef FREE_SUSTAIN_EN
   logic              sus_s1;
   logic              sus_s2;
   logic [N_KEYS-1:0] latch;

   // While sustain is down every press edge is remembered. Once the
   // synchronised sustain is low the latch is cleared on every edge, so the
   // first low cycle (the falling edge) empties it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sus_s1 <= 1'b0;
         sus_s2 <= 1'b0;
         latch  <= '0;
      end else begin
         sus_s1 <= bus.sustain;
         sus_s2 <= sus_s1;
         latch  <= sus_s2 ? (latch | press) : '0;
      end
   end

   // Masking with sus_s2 makes the sound vector drop back to live keys on the
   // very edge where sustain falls, not one edge later.
   assign held = live | (sus_s2 ? latch : '0);
`else
   logic sustain_unused;

   assign sustain_unused = bus.sustain;
   assign held           = live;
`endif

   // ---------------------------------------------------------------------------
   // Polyphonic note vector: key i sounds on notes[N_KEYS-1-i].
   // ---------------------------------------------------------------------------
   logic [N_KEYS-1:0] notes_nxt;
   logic [N_KEYS-1:0] notes_q;

   always_comb begin
      // NOTE: the default assignment up front keeps this block purely
      // combinational even if the loop below were ever made conditional.
      notes_nxt = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         notes_nxt[N_KEYS-1-i] = held[i];
      end
   end

   // Lowest set bit of a key vector; returns 0 for an empty vector.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [N_KEYS-1:0] v);
      lowest_set = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (v[i]) begin
            lowest_set = IDX_W'(i);
         end
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Monophonic last-note-priority channel plus the registered note vector.
   // A fresh press always takes priority over a release of the current note.
   // ---------------------------------------------------------------------------
   mono_state_t      mono_state;
   logic             note_valid_q;
   logic [IDX_W-1:0] note_idx_q;
   logic             note_on_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: everything here is a plain register, so all of it is reset;
         // there is no storage array that would be left out of reset.
         mono_state   <= ST_IDLE;
         note_valid_q <= 1'b0;
         note_idx_q   <= '0;
         note_on_q    <= 1'b0;
         notes_q      <= '0;
      end else begin
         notes_q   <= notes_nxt;
         note_on_q <= 1'b0;
         case (mono_state)
            ST_IDLE: begin
               if (|press) begin
                  mono_state   <= ST_HOLD;
                  note_valid_q <= 1'b1;
                  note_idx_q   <= lowest_set(press);
                  note_on_q    <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (|press) begin
                  // Retrigger even when the index does not change.
                  note_idx_q <= lowest_set(press);
                  note_on_q  <= 1'b1;
               end else if (!held[note_idx_q]) begin
                  if (|held) begin
                     note_idx_q <= lowest_set(held);
                  end else begin
                     // note_idx keeps its last value for the display.
                     mono_state   <= ST_IDLE;
                     note_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               mono_state   <= ST_IDLE;
               note_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.notes      = notes_q;
   assign bus.shift      = shift_q;
   assign bus.note_valid = note_valid_q;
   assign bus.note_idx   = note_idx_q;
   assign bus.note_on    = note_on_q;

endmodule
